ripple_adder_reg: RTL and testbench
===================================

Name: ripple_adder_reg

Overview:
- Registered ripple-carry adder of WIDTH bits (default 4), built as a chain of 1-bit full-adder cells.
- Adds two unsigned/two's-complement operands plus a carry-in.
- Exposes the combinational result and a one-cycle registered result with carry, signed-overflow and zero flags.
- Used as the basic arithmetic primitive for small datapaths.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in into bit 0
- in_valid  input  1  qualifies a/b/cin for capture this cycle
- sum_comb  output  WIDTH  combinational sum of current a+b+cin
- cout_comb  output  1  combinational carry-out of current inputs
- sum  output  WIDTH  registered sum
- cout  output  1  registered carry-out
- overflow  output  1  registered signed overflow
- zero  output  1  registered flag, sum == 0
- out_valid  output  1  registered result valid

Behaviour:
- Reset is synchronous and active-low: on a rising clk with rst_n=0, sum=0, cout=0, overflow=0, zero=0, out_valid=0.
- During reset, combinational outputs still track the inputs.
- Full-adder cell i:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i])
  - c[0] = cin
- Cells are chained LSB to MSB (ripple). sum_comb = s[WIDTH-1:0] and cout_comb = c[WIDTH].
- Arithmetic identity: {cout_comb, sum_comb} == a + b + cin, computed in WIDTH+1 bits. No truncation other than dropping bits above WIDTH.
- Overflow (two's complement) = c[WIDTH] ^ c[WIDTH-1]. This equals "operands share a sign and the sum sign differs". For WIDTH=1, overflow = c[1] ^ cin.
- Latency: one cycle. At a rising clk with rst_n=1 and in_valid=1, the block registers:
  - sum <= sum_comb
  - cout <= cout_comb
  - overflow <= computed flag
  - zero <= (sum_comb == 0)
  - out_valid <= 1
- At a rising clk with rst_n=1 and in_valid=0: sum, cout, overflow and zero hold their previous values, and out_valid <= 0.
- No backpressure; a new operand set may be accepted every cycle (full throughput).
- Wrap-around: all-ones + 1 yields sum=0, cout=1, zero=1.
- Reset asserted mid-stream overrides in_valid. The result captured in that cycle is discarded and out_valid=0 on the next cycle.
- Outputs are not X after the first reset edge. Behaviour before the first reset is undefined.

Test Plan:
- 1-bit exhaustive, WIDTH=1: toggle a every 2, b every 4, cin every 8 time units, covering all 8 combinations.
  - Required: sum_comb = a^b^cin, cout_comb = majority(a,b,cin).
  - Specifically 1+1+1 -> sum=1, cout=1 and 1+0+0 -> sum=1, cout=0.
- Basic 4-bit case: a=0001, b=0100, cin=0, in_valid=1 -> sum_comb=0101, cout_comb=0 immediately. Next edge: sum=0101, cout=0, overflow=0, zero=0, out_valid=1.
- Carry/wrap: a=1111, b=0001, cin=0 -> sum=0000, cout=1, zero=1, overflow=0. Also a=1111, b=1111, cin=1 -> sum=1111, cout=1.
- Signed overflow:
  - a=0111, b=0001, cin=0 -> sum=1000, overflow=1, cout=0.
  - a=1000, b=1000 -> sum=0000, cout=1, overflow=1, zero=1.
- Hold/valid and reset:
  - Capture 0011+0010 (sum=0101), then drop in_valid with changed inputs -> registered sum stays 0101 and out_valid=0.
  - Assert rst_n=0 with in_valid=1 -> next edge all registered outputs 0.
- Random regression: 1000 random a/b/cin values with random in_valid. Checker compares {cout,sum} against a+b+cin delayed by one cycle, and overflow/zero against a reference model.

Source files
------------

// File: rtl/ripple_adder_if.sv
// Operand/result bundle for ripple_adder_reg.
// The master drives the operands and in_valid. The slave returns the
// combinational result and the registered result with its flags.
interface ripple_adder_if #(
  parameter int unsigned WIDTH = 4
) ();

  // Operands
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;

  // Combinational result
  logic [WIDTH-1:0] sum_comb;
  logic             cout_comb;

  // Registered result
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             out_valid;

  modport master (
    output a, b, cin, in_valid,
    input  sum_comb, cout_comb, sum, cout, overflow, zero, out_valid
  );

  modport slave (
    input  a, b, cin, in_valid,
    output sum_comb, cout_comb, sum, cout, overflow, zero, out_valid
  );

endinterface

// File: rtl/ripple_adder_reg.sv
// Registered ripple-carry adder built from a chain of 1-bit full-adder cells.
// The combinational sum and carry-out follow the operands, even during reset.
// The registered sum, carry, overflow and zero flags update one cycle after
// each valid operand set. They hold their values while in_valid is low.
module ripple_adder_reg #(
  parameter int unsigned WIDTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  ripple_adder_if.slave   bus
);

  // Carry chain: carry[i] enters cell i, and carry[WIDTH] is the carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;
  logic             zero_s;

  // Registered state
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;

  // Full-adder chain from LSB to MSB. A sequential loop keeps the chain
  // free of a self-referencing continuous assignment.
  always_comb begin
    carry    = '0;
    sum_s    = '0;
    carry[0] = bus.cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum_s[i]   = bus.a[i] ^ bus.b[i] ^ carry[i];
      carry[i+1] = (bus.a[i] & bus.b[i]) |
                   (bus.a[i] & carry[i]) |
                   (bus.b[i] & carry[i]);
    end
  end

  // Signed overflow: the carry into the MSB differs from the carry out of it.
  // When WIDTH is 1, carry[WIDTH-1] is cin.
  assign ovf_s  = carry[WIDTH] ^ carry[WIDTH-1];
  assign zero_s = (sum_s == '0);

  // Next state: capture when in_valid is high, otherwise hold. out_valid
  // follows in_valid.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    valid_d = bus.in_valid;
    if (bus.in_valid) begin
      sum_d  = sum_s;
      cout_d = carry[WIDTH];
      ovf_d  = ovf_s;
      zero_d = zero_s;
    end
  end

  // Result registers with synchronous active-low reset. Reset overrides in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sum_comb  = sum_s;
  assign bus.cout_comb = carry[WIDTH];
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_ripple_adder_reg.sv
// Self-checking bench for ripple_adder_reg. It uses a 4-bit instance for
// directed vectors, hold/reset sequences and random regression, plus a
// 1-bit instance for the exhaustive full-adder truth table.
module tb_ripple_adder_reg;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  ripple_adder_if #(.WIDTH(4)) bus4 ();
  ripple_adder_if #(.WIDTH(1)) bus1 ();

  ripple_adder_reg #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  ripple_adder_reg #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  vec_t vecs[6];

  // Reference model state: the registered result the DUT should show.
  logic [3:0] m_sum;
  logic       m_cout;
  logic       m_ovf;
  logic       m_zero;
  logic       m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: unsigned sum for sum and carry, signed range for overflow.
  task automatic ref_add(input logic [3:0] a, input logic [3:0] b, input logic cin,
                         output logic [3:0] s, output logic co, output logic ov,
                         output logic z);
    int unsigned u;
    int sa, sb, sr;
    u  = int'(a) + int'(b) + int'(cin);
    s  = u[3:0];
    co = (u >= 16);
    sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
    sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
    sr = sa + sb + int'(cin);
    ov = (sr > 7) || (sr < -8);
    z  = (s == 4'd0);
  endtask

  task automatic check_regs(input string tag, input logic [3:0] s, input logic co,
                            input logic ov, input logic z, input logic v);
    chk({tag, ".sum"}, 32'(bus4.sum), 32'(s));
    chk({tag, ".cout"}, 32'(bus4.cout), 32'(co));
    chk({tag, ".ovf"}, 32'(bus4.overflow), 32'(ov));
    chk({tag, ".zero"}, 32'(bus4.zero), 32'(z));
    chk({tag, ".valid"}, 32'(bus4.out_valid), 32'(v));
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input logic v);
    bus4.a        = a;
    bus4.b        = b;
    bus4.cin      = cin;
    bus4.in_valid = v;
  endtask

  initial begin
    logic [3:0] rs;
    logic       rco, rov, rz;
    logic [3:0] ra, rb;
    logic       rc, rv;
    logic [1:0] exp1;

    checks = 0;
    errors = 0;

    vecs[0] = '{a: 4'b0001, b: 4'b0100, cin: 1'b0, sum: 4'b0101, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
    vecs[1] = '{a: 4'b1111, b: 4'b0001, cin: 1'b0, sum: 4'b0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1};
    vecs[2] = '{a: 4'b1111, b: 4'b1111, cin: 1'b1, sum: 4'b1111, cout: 1'b1, ovf: 1'b0, zero: 1'b0};
    vecs[3] = '{a: 4'b0111, b: 4'b0001, cin: 1'b0, sum: 4'b1000, cout: 1'b0, ovf: 1'b1, zero: 1'b0};
    vecs[4] = '{a: 4'b1000, b: 4'b1000, cin: 1'b0, sum: 4'b0000, cout: 1'b1, ovf: 1'b1, zero: 1'b1};
    vecs[5] = '{a: 4'b0110, b: 4'b0101, cin: 1'b1, sum: 4'b1100, cout: 1'b0, ovf: 1'b1, zero: 1'b0};

    // Reset with in_valid high: the registers must clear, and the comb path still tracks.
    rst_n = 1'b0;
    drive4(4'b0011, 4'b0010, 1'b0, 1'b1);
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.cin = 1'b0; bus1.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_regs("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.sum_comb", 32'(bus4.sum_comb), 32'd5);

    // 1-bit exhaustive sweep: a toggles every 2, b every 4, cin every 8 time units.
    for (int i = 0; i < 8; i++) begin
      bus1.a   = i[0];
      bus1.b   = i[1];
      bus1.cin = i[2];
      #1;
      exp1 = 2'(int'(i[0]) + int'(i[1]) + int'(i[2]));
      chk($sformatf("w1.sum_comb[%0d]", i), 32'(bus1.sum_comb), 32'(exp1[0]));
      chk($sformatf("w1.cout_comb[%0d]", i), 32'(bus1.cout_comb), 32'(exp1[1]));
      #1;
    end

    @(negedge clk);
    rst_n = 1'b1;
    drive4(4'd0, 4'd0, 1'b0, 1'b0);

    // 1-bit registered capture of 1+1+1: sum=1, cout=1, no signed overflow.
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("w1.sum", 32'(bus1.sum), 32'd1);
    chk("w1.cout", 32'(bus1.cout), 32'd1);
    chk("w1.ovf", 32'(bus1.overflow), 32'd0);
    chk("w1.valid", 32'(bus1.out_valid), 32'd1);
    @(negedge clk);
    bus1.a = 1'b1; bus1.b = 1'b0; bus1.cin = 1'b0;
    @(posedge clk); #1;
    chk("w1.100.sum", 32'(bus1.sum), 32'd1);
    chk("w1.100.cout", 32'(bus1.cout), 32'd0);
    @(negedge clk);
    bus1.in_valid = 1'b0;

    // Table-driven directed vectors.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive4(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
      #1;
      chk($sformatf("vec%0d.sum_comb", i), 32'(bus4.sum_comb), 32'(vecs[i].sum));
      chk($sformatf("vec%0d.cout_comb", i), 32'(bus4.cout_comb), 32'(vecs[i].cout));
      @(posedge clk); #1;
      check_regs($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf,
                 vecs[i].zero, 1'b1);
    end

    // Hold: capture 3+2, then drop in_valid with new operands.
    @(negedge clk);
    drive4(4'b0011, 4'b0010, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_regs("hold.cap", 4'b0101, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive4(4'b1001, 4'b0110, 1'b0, 1'b0);
    #1;
    chk("hold.sum_comb", 32'(bus4.sum_comb), 32'hf);
    @(posedge clk); #1;
    check_regs("hold.idle", 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream overrides in_valid.
    @(negedge clk);
    drive4(4'b0001, 4'b0001, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_regs("mid.cap", 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    drive4(4'b0111, 4'b0111, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_regs("mid.rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive4(4'd0, 4'd0, 1'b0, 1'b0);

    // Random regression against the arithmetic model.
    m_sum = 4'd0; m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b0; m_valid = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1));
      drive4(ra, rb, rc, rv);
      ref_add(ra, rb, rc, rs, rco, rov, rz);
      #1;
      if (bus4.sum_comb !== rs || bus4.cout_comb !== rco)
        chk($sformatf("rnd%0d.comb", n), 32'({bus4.cout_comb, bus4.sum_comb}),
            32'({rco, rs}));
      else
        checks++;
      @(posedge clk); #1;
      if (rv) begin
        m_sum = rs; m_cout = rco; m_ovf = rov; m_zero = rz;
      end
      m_valid = rv;
      chk($sformatf("rnd%0d.res", n),
          32'({bus4.out_valid, bus4.zero, bus4.overflow, bus4.cout, bus4.sum}),
          32'({m_valid, m_zero, m_ovf, m_cout, m_sum}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
